// File: rtl/sobel_frame_ctrl_pkg.sv
// Shared types and constants for the Sobel frame sequencer.
// Holds the FSM state encoding and the header/dimension limits.
package sobel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_H,
    STREAM,
    DRAIN,
    ERROR
  } state_t;

  localparam int          HDR_BYTES = 2;
  localparam logic [15:0] MIN_DIM   = 16'd3;

endpackage

// File: rtl/sobel_frame_ctrl_if.sv
// Stream bundle between UART side, kernel and the frame sequencer.
// master = sequencer, slave = surrounding datapath / environment.
interface sobel_frame_ctrl_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic [DATA_BITS-1:0] krn_data;
  logic                 krn_valid;
  logic                 krn_sof;
  logic                 krn_eol;
  logic [15:0]          krn_x;
  logic [15:0]          krn_y;
  logic [15:0]          krn_width;
  logic [15:0]          krn_height;
  logic [DATA_BITS-1:0] res_data;
  logic                 res_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 busy;
  logic                 frame_done;
  logic                 err_dim;
  logic                 overflow;

  modport master (
    input  rx_data, rx_valid,
    input  res_data, res_valid,
    input  tx_ready,
    output krn_data, krn_valid,
    output krn_sof, krn_eol,
    output krn_x, krn_y,
    output krn_width, krn_height,
    output tx_data, tx_valid,
    output busy, frame_done,
    output err_dim, overflow
  );

  modport slave (
    output rx_data, rx_valid,
    output res_data, res_valid,
    output tx_ready,
    input  krn_data, krn_valid,
    input  krn_sof, krn_eol,
    input  krn_x, krn_y,
    input  krn_width, krn_height,
    input  tx_data, tx_valid,
    input  busy, frame_done,
    input  err_dim, overflow
  );

endinterface

// File: rtl/sobel_out_fifo.sv
// First-word-fall-through result buffer for the TX side.
// A push on a full FIFO is dropped unless a pop frees a slot.
module sobel_out_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DATA_BITS-1:0]         push_data,
  input  logic                         pop,
  output logic [DATA_BITS-1:0]         pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(FIFO_DEPTH):0]  count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, wr_d;
  logic [AW-1:0]        rd_q, rd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 wr_en, rd_en;

  assign full     = cnt_q == CW'(FIFO_DEPTH);
  assign empty    = cnt_q == '0;
  assign count    = cnt_q;
  assign pop_data = mem_q[rd_q];

  always_comb begin
    rd_en = pop && !empty;
    wr_en = push && (!full || rd_en);
    wr_d  = wr_q + AW'(wr_en);
    rd_d  = rd_q + AW'(rd_en);
    cnt_d = cnt_q + CW'(wr_en) - CW'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer: header parse, pixel tagging, result buffering.
// Optional TX output header enabled by SOBEL_CTRL_HDR_EN.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int MAX_WIDTH  = 32,
  parameter int MAX_HEIGHT = 255,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  sobel_frame_ctrl_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t               state_q, state_d;
  logic [15:0]          width_q, width_d;
  logic [15:0]          height_q, height_d;
  logic [15:0]          target_q, target_d;
  logic [15:0]          x_q, x_d, y_q, y_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [15:0]          krn_x_q, krn_x_d;
  logic [15:0]          krn_y_q, krn_y_d;
  logic [DATA_BITS-1:0] krn_data_q, krn_data_d;
  logic                 krn_valid_q, krn_valid_d;
  logic                 krn_sof_q, krn_sof_d;
  logic                 krn_eol_q, krn_eol_d;
  logic                 frame_done_q, frame_done_d;
  logic                 err_dim_q, err_dim_d;
  logic                 overflow_q, overflow_d;

  logic [15:0]          hgt_in;
  logic                 dim_ok, go_stream;
  logic                 res_push, push_ok, pop;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_cnt, fifo_cnt_nx;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 hdr_pend, hdr_idle_nx;
  logic [DATA_BITS-1:0] hdr_byte;

  sobel_out_fifo #(
    .DATA_BITS (DATA_BITS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (res_push),
    .push_data(bus.res_data),
    .pop      (pop),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  assign res_push = bus.res_valid &&
                    (state_q == STREAM || state_q == DRAIN);
  assign pop      = bus.tx_ready && !fifo_empty && !hdr_pend;
  assign push_ok  = res_push && (!fifo_full || pop);
  assign fifo_cnt_nx = fifo_cnt + CW'(push_ok) - CW'(pop);

  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    height_d     = height_q;
    target_d     = target_q;
    x_d          = x_q;
    y_d          = y_q;
    cnt_d        = cnt_q;
    krn_x_d      = krn_x_q;
    krn_y_d      = krn_y_q;
    krn_data_d   = krn_data_q;
    krn_valid_d  = 1'b0;
    krn_sof_d    = 1'b0;
    krn_eol_d    = 1'b0;
    frame_done_d = 1'b0;
    err_dim_d    = err_dim_q;
    overflow_d   = overflow_q;
    go_stream    = 1'b0;
    hgt_in       = 16'(bus.rx_data);
    dim_ok = width_q >= MIN_DIM &&
             width_q <= 16'(MAX_WIDTH) &&
             hgt_in >= MIN_DIM &&
             hgt_in <= 16'(MAX_HEIGHT);

    if (pop) cnt_d = cnt_q + 16'd1;
    if (res_push && fifo_full && !pop) overflow_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (bus.rx_valid) begin
          width_d    = 16'(bus.rx_data);
          overflow_d = 1'b0;
          cnt_d      = '0;
          state_d    = HDR_H;
        end
      end
      HDR_H: begin
        if (bus.rx_valid) begin
          height_d = hgt_in;
          target_d = (width_q - 16'd2) * (hgt_in - 16'd2);
          x_d      = '0;
          y_d      = '0;
          if (dim_ok) begin
            state_d   = STREAM;
            go_stream = 1'b1;
          end else begin
            state_d   = ERROR;
            err_dim_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (bus.rx_valid) begin
          krn_valid_d = 1'b1;
          krn_data_d  = bus.rx_data;
          krn_x_d     = x_q;
          krn_y_d     = y_q;
          krn_sof_d   = x_q == '0 && y_q == '0;
          krn_eol_d   = x_q == width_q - 16'd1;
          if (x_q == width_q - 16'd1) begin
            x_d = '0;
            y_d = y_q + 16'd1;
            if (y_q == height_q - 16'd1) state_d = DRAIN;
          end else begin
            x_d = x_q + 16'd1;
          end
        end
      end
      DRAIN: begin
        // Evaluated on next-cycle values so done lands right after the last pop.
        if (cnt_d == target_q && fifo_cnt_nx == '0 && hdr_idle_nx) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      ERROR: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      width_q      <= '0;
      height_q     <= '0;
      target_q     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      cnt_q        <= '0;
      krn_x_q      <= '0;
      krn_y_q      <= '0;
      krn_data_q   <= '0;
      krn_valid_q  <= 1'b0;
      krn_sof_q    <= 1'b0;
      krn_eol_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_dim_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      target_q     <= target_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cnt_q        <= cnt_d;
      krn_x_q      <= krn_x_d;
      krn_y_q      <= krn_y_d;
      krn_data_q   <= krn_data_d;
      krn_valid_q  <= krn_valid_d;
      krn_sof_q    <= krn_sof_d;
      krn_eol_q    <= krn_eol_d;
      frame_done_q <= frame_done_d;
      err_dim_q    <= err_dim_d;
      overflow_q   <= overflow_d;
    end
  end

`ifdef SOBEL_CTRL_HDR_EN
  logic [1:0] hdr_q, hdr_d;

  always_comb begin
    hdr_d = hdr_q;
    if (go_stream) hdr_d = 2'(HDR_BYTES);
    else if (hdr_q != '0 && bus.tx_ready) hdr_d = hdr_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) hdr_q <= '0;
    else        hdr_q <= hdr_d;
  end

  assign hdr_pend    = hdr_q != '0;
  assign hdr_idle_nx = hdr_d == '0;
  assign hdr_byte    = (hdr_q == 2'(HDR_BYTES)) ?
                       DATA_BITS'(width_q - 16'd2) :
                       DATA_BITS'(height_q - 16'd2);
`else
  assign hdr_pend    = 1'b0;
  assign hdr_idle_nx = 1'b1;
  assign hdr_byte    = '0;
`endif

  assign bus.tx_valid   = hdr_pend || !fifo_empty;
  assign bus.tx_data    = hdr_pend   ? hdr_byte :
                          fifo_empty ? '0 : fifo_data;
  assign bus.krn_data   = krn_data_q;
  assign bus.krn_valid  = krn_valid_q;
  assign bus.krn_sof    = krn_sof_q;
  assign bus.krn_eol    = krn_eol_q;
  assign bus.krn_x      = krn_x_q;
  assign bus.krn_y      = krn_y_q;
  assign bus.krn_width  = width_q;
  assign bus.krn_height = height_q;
  assign bus.busy       = state_q != IDLE;
  assign bus.frame_done = frame_done_q;
  assign bus.err_dim    = err_dim_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl (header on/off via SOBEL_CTRL_HDR_EN).
module tb_sobel_frame_ctrl;
  import sobel_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobel_frame_ctrl_if #(.DATA_BITS(8)) bus ();

  sobel_frame_ctrl #(
    .DATA_BITS (8),
    .MAX_WIDTH (32),
    .MAX_HEIGHT(255),
    .FIFO_DEPTH(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

`ifdef SOBEL_CTRL_HDR_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;
  int ncyc = 0;
  int done_cnt = 0;
  int done_n = 0;
  int tx_last_n = 0;
  logic [31:0] krn_q[$];
  logic [7:0]  tx_q[$];

  always @(negedge clk) begin
    ncyc++;
    if (bus.krn_valid)
      krn_q.push_back({bus.krn_data, bus.krn_x[7:0], bus.krn_y[7:0],
                       6'd0, bus.krn_sof, bus.krn_eol});
    if (bus.tx_valid && bus.tx_ready) begin
      tx_q.push_back(bus.tx_data);
      tx_last_n = ncyc;
    end
    if (bus.frame_done) begin
      done_cnt++;
      done_n = ncyc;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic put(logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    cyc();
    bus.rx_valid = 1'b0;
  endtask

  task automatic res(logic [7:0] b);
    bus.res_valid = 1'b1;
    bus.res_data  = b;
    cyc();
    bus.res_valid = 1'b0;
  endtask

  task automatic wait_done(int base, int budget);
    int i = 0;
    while (done_cnt == base && i < budget) begin
      cyc();
      i++;
    end
    chk("done_seen", 32'(done_cnt - base), 32'd1);
  endtask

  task automatic chk_tx(string tag, int t0, logic [7:0] exp[$]);
    chk({tag, "_len"}, 32'(tx_q.size() - t0), 32'(exp.size()));
    foreach (exp[i]) chk(tag, 32'(tx_q[t0 + i]), 32'(exp[i]));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int k0, t0, d0;
    logic [7:0] exp[$];
    logic [31:0] e;

    bus.rx_valid  = 1'b0;
    bus.rx_data   = '0;
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    bus.tx_ready  = 1'b0;
    rst_n = 1'b0;
    cyc();
    cyc();
    chk("rst_krn_valid", 32'(bus.krn_valid), 0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_err", 32'(bus.err_dim), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_width", 32'(bus.krn_width), 0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst_n = 1'b1;
    cyc();

    // 5x4 frame, 6 results, tx always ready
    bus.tx_ready = 1'b1;
    k0 = krn_q.size();
    t0 = tx_q.size();
    d0 = done_cnt;
    put(8'd5);
    put(8'd4);
    chk("dims", {bus.krn_width, bus.krn_height}, {16'd5, 16'd4});
    chk("state_stream", 32'(dut.state_q), 32'(STREAM));
    for (int i = 0; i < 20; i++) put(8'(i));
    chk("state_drain", 32'(dut.state_q), 32'(DRAIN));
    for (int i = 0; i < 6; i++) res(8'hA0 + 8'(i));
    wait_done(d0, 40);
    chk("krn_len", 32'(krn_q.size() - k0), 32'd20);
    for (int i = 0; i < 20; i++) begin
      e = {8'(i), 8'(i % 5), 8'(i / 5), 6'd0, i == 0, i % 5 == 4};
      chk("krn_pix", krn_q[k0 + i], e);
    end
    exp = {};
    if (HDR) begin
      exp.push_back(8'd3);
      exp.push_back(8'd2);
    end
    for (int i = 0; i < 6; i++) exp.push_back(8'hA0 + 8'(i));
    chk_tx("tx54", t0, exp);
    chk("done_lat", 32'(done_n - tx_last_n), 32'd1);
    chk("busy_low", 32'(bus.busy), 0);

    // Oversized width is rejected and locks up until reset
    do_reset();
    put(8'd33);
    put(8'd4);
    chk("err_dim", 32'(bus.err_dim), 1);
    chk("err_state", 32'(dut.state_q), 32'(ERROR));
    chk("err_busy", 32'(bus.busy), 1);
    k0 = krn_q.size();
    for (int i = 0; i < 50; i++) put(8'(i));
    res(8'h55);
    cyc();
    chk("err_no_krn", 32'(krn_q.size() - k0), 0);
    chk("err_no_tx", 32'(bus.tx_valid), 0);
    rst_n = 1'b0;
    cyc();
    chk("err_clr", 32'(bus.err_dim), 0);
    chk("err_idle", 32'(dut.state_q), 32'(IDLE));
    rst_n = 1'b1;

    // Limit dimensions: 32x3 accepted, height 2 rejected
    put(8'd32);
    put(8'd3);
    chk("max_w_ok", 32'(dut.state_q), 32'(STREAM));
    do_reset();
    put(8'd3);
    put(8'd2);
    chk("min_h_err", 32'(bus.err_dim), 1);

    // 19x3 frame wants 17 results; FIFO only holds 16
    do_reset();
    bus.tx_ready = 1'b0;
    t0 = tx_q.size();
    d0 = done_cnt;
    put(8'd19);
    put(8'd3);
    for (int i = 0; i < 57; i++) put(8'(i));
    chk("ovf_drain", 32'(dut.state_q), 32'(DRAIN));
    for (int i = 0; i < 17; i++) res(8'h10 + 8'(i));
    cyc();
    chk("ovf_flag", 32'(bus.overflow), 1);
    chk("ovf_level", 32'(dut.fifo_cnt), 32'd16);
    bus.tx_ready = 1'b1;
    repeat (40) cyc();
    exp = {};
    if (HDR) begin
      exp.push_back(8'd17);
      exp.push_back(8'd1);
    end
    for (int i = 0; i < 16; i++) exp.push_back(8'h10 + 8'(i));
    chk_tx("ovf_tx", t0, exp);
    chk("ovf_no_done", 32'(done_cnt - d0), 0);
    chk("ovf_busy", 32'(bus.busy), 1);
    chk("ovf_empty", 32'(bus.tx_valid), 0);

    // Reset mid-stream with FIFO contents pending
    do_reset();
    bus.tx_ready = 1'b0;
    put(8'd5);
    put(8'd4);
    for (int i = 0; i < 7; i++) put(8'(i + 1));
    res(8'hEE);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'd7;
    rst_n = 1'b0;
    cyc();
    bus.rx_valid = 1'b0;
    rst_n = 1'b1;
    chk("mr_krn_valid", 32'(bus.krn_valid), 0);
    chk("mr_krn_xy", {bus.krn_x, bus.krn_y}, 0);
    chk("mr_krn_data", 32'(bus.krn_data), 0);
    chk("mr_krn_dims", {bus.krn_width, bus.krn_height}, 0);
    chk("mr_tx", {23'd0, bus.tx_valid, bus.tx_data}, 0);
    chk("mr_flags", {28'd0, bus.busy, bus.frame_done,
                     bus.err_dim, bus.overflow}, 0);
    chk("mr_fifo", 32'(dut.fifo_cnt), 0);

    // 3x3 frame after reset: a single result
    bus.tx_ready = 1'b1;
    t0 = tx_q.size();
    d0 = done_cnt;
    put(8'd3);
    put(8'd3);
    for (int i = 0; i < 9; i++) put(8'(i));
    res(8'h77);
    wait_done(d0, 40);
    exp = {};
    if (HDR) begin
      exp.push_back(8'd1);
      exp.push_back(8'd1);
    end
    exp.push_back(8'h77);
    chk_tx("tx33", t0, exp);
    chk("done33_lat", 32'(done_n - tx_last_n), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sobel_frame_ctrl.md
# sobel_frame_ctrl

Frame-level sequencer between the UART receive stream and the Sobel kernel datapath. It parses the 2-byte image header (width, height) and validates the dimensions. It forwards pixels to the kernel tagged with coordinates and line/frame markers, buffers kernel results for the UART transmit side, and optionally emits an output header. It signals completion after exactly (W-2)*(H-2) results have been transmitted.

## Interface

- DATA_BITS, 8: pixel and header byte width
- MAX_WIDTH, 32: largest accepted image width; must match kernel line-buffer depth
- MAX_HEIGHT, 255: largest accepted image height
- FIFO_DEPTH, 16: result buffer entries, power of two

- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- rx_data  in  DATA_BITS  byte from UART RX
- rx_valid  in  1  rx_data valid; cannot be stalled
- krn_data  out  DATA_BITS  pixel to kernel
- krn_valid  out  1  pixel strobe to kernel
- krn_sof  out  1  first pixel of frame (x=0, y=0)
- krn_eol  out  1  last pixel of a row (x=W-1)
- krn_x, krn_y  out  16 each  coordinates of the current krn_data
- krn_width, krn_height  out  16 each  latched dimensions
- res_data  in  DATA_BITS  kernel result
- res_valid  in  1  result strobe
- tx_data  out  DATA_BITS  byte to UART TX
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX accepts; transfer when tx_valid && tx_ready
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at end of frame
- err_dim  out  1  sticky; header rejected
- overflow  out  1  sticky; a result was dropped on a full FIFO

## Operation

- States: IDLE, HDR_H, STREAM, DRAIN, ERROR.
- IDLE: on rx_valid, latch width = rx_data. Clear overflow and the result counter. Go to HDR_H.
- HDR_H: on rx_valid, latch height = rx_data.
  - If width<3, width>MAX_WIDTH, height<3 or height>MAX_HEIGHT: go to ERROR and set err_dim.
  - Otherwise go to STREAM and arm the header emitter when enabled.
- STREAM: each rx_valid byte is forwarded as one pixel.
  - x counts 0..W-1 and wraps to 0 with y+1.
  - krn_sof is asserted when x=0 and y=0; krn_eol is asserted when x=W-1.
  - The pixel with x=W-1, y=H-1 moves the state to DRAIN.
- DRAIN: rx_valid bytes are ignored and not forwarded. Stay until the result counter has reached (W-2)*(H-2) transmitted bytes, the FIFO is empty and the header has been sent. Then pulse frame_done and return to IDLE.
- ERROR: all input is ignored. Exit only by reset.
- Results: every res_valid cycle in STREAM or DRAIN pushes res_data into the FIFO.
  - If the FIFO is full, the push drops the byte and sets overflow.
  - A push and a pop in the same cycle on a full FIFO succeed.
  - res_valid in IDLE, HDR_H or ERROR is ignored.
- Product (W-2)*(H-2) is computed at 16 bits unsigned; limits guarantee no overflow.
- The transmitted counter counts only FIFO bytes, never header bytes.

## Timing

- Reset values:
  - All outputs 0, state IDLE, FIFO empty.
  - err_dim and overflow are cleared only by reset; overflow is also cleared on the next width byte.
- Pixel path: rx byte in cycle N → krn_valid/krn_data/tags registered, valid in N+1.
- FIFO is first-word fall-through: tx_valid rises the cycle after the push into an empty FIFO.
- tx_data is held stable while tx_valid && !tx_ready.
- Header bytes have priority over FIFO output; FIFO bytes go out only after both header bytes are sent.
- frame_done is asserted the cycle after the final tx transfer.
- Reset asserted mid-frame: next edge returns to IDLE and discards FIFO contents.

## Configuration

- SOBEL_CTRL_HDR_EN defined: on entry to STREAM, tx emits W-2 then H-2 before any result.
- SOBEL_CTRL_HDR_EN undefined: no header is emitted and the header emitter logic is absent. The completion condition ignores header state.

## Structure

- Package sobel_pkg: state_t enum, header-byte count constant, minimum-dimension constant (3).
- Sub-module sobel_out_fifo: synchronous FWFT FIFO with parameters DATA_BITS and FIFO_DEPTH. It provides push/pop/full/empty and drops pushes when full without a pop.

## Test plan

- Header 5,4, then 20 pixels 0..19: krn_x/krn_y sequence correct; krn_eol at pixels 4,9,14,19; krn_sof only on pixel 0; state DRAIN after pixel 19.
- Same frame, kernel returns 6 results with tx_ready=1, HDR_EN defined: tx sequence 3,2,r0..r5; frame_done one cycle after r5; busy falls.
- Header 33,4 with MAX_WIDTH=32: err_dim=1, state ERROR; 50 further bytes produce no krn_valid; rst_n low clears err_dim.
- tx_ready=0 with 17 results pushed at FIFO_DEPTH=16: overflow=1 and 16 entries held; release tx_ready to drain 16 bytes; no frame_done, since the count is short by one.
- rst_n low for one cycle during STREAM at pixel 7: all outputs 0 next cycle; a new header 3,3 plus 9 pixels then runs normally with 1 result and frame_done.
- Without HDR_EN, header 3,3: first tx byte is the single result; frame_done follows.
